// File: rtl/nibble_pkg.sv
// Shared nibble packer/unpacker definitions: digit width, FSM states, index-width helper.
package nibble_pkg;

  localparam int DIGIT_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Index width for n positions; never below 1 so a single-digit word still has a port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_unpacker_lead_zero_cnt.sv
// Leading-zero-digit counter, capped at NUM_DIGITS-1; built only with NIBBLE_UNPACK_LZS_EN.
// Latency: combinational. Backpressure: none.
`ifdef NIBBLE_UNPACK_LZS_EN
module lead_zero_cnt
  import nibble_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DIGIT_W = DIGIT_W_DEF,
  localparam int NUM_DIGITS = DATA_W / DIGIT_W,
  localparam int IDX_W      = clog2(NUM_DIGITS)
) (
  input  logic [DATA_W-1:0] word,
  output logic [IDX_W-1:0]  z
);

  logic found;

  // The least-significant digit is never examined, which gives the cap for free.
  always_comb begin
    z     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      if (!found && word[DATA_W-1-i*DIGIT_W -: DIGIT_W] == '0)
        z = IDX_W'(i + 1);
      else
        found = 1'b1;
    end
  end

endmodule
`endif

// File: rtl/nibble_unpacker.sv
// Serialises a packed word into DIGIT_W digits, MS first; NIBBLE_UNPACK_LZS_EN drops leading zeros.
// Latency: first digit the cycle after load, one digit per accepted cycle, one idle cycle per word.
// Backpressure: out_ready low holds digit/idx/last indefinitely; in_ready stays low until the word drains.
module nibble_unpacker
  import nibble_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DIGIT_W = DIGIT_W_DEF,
  localparam int NUM_DIGITS = DATA_W / DIGIT_W,
  localparam int IDX_W      = clog2(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [IDX_W-1:0]   out_idx
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [IDX_W-1:0]    count, count_nxt;
  logic [DATA_W-1:0]   load_word;
  logic [IDX_W-1:0]    load_cnt;

`ifdef NIBBLE_UNPACK_LZS_EN
  logic [IDX_W-1:0] lz;

  lead_zero_cnt #(
    .DATA_W  (DATA_W),
    .DIGIT_W (DIGIT_W)
  ) u_lzc (
    .word (in_word),
    .z    (lz)
  );

  // Pre-align so the first significant digit sits in the output slot.
  assign load_word = in_word << (lz * DIGIT_W);
  assign load_cnt  = IDX_W'(NUM_DIGITS - 1) - lz;
`else
  assign load_word = in_word;
  assign load_cnt  = IDX_W'(NUM_DIGITS - 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    count_nxt = count;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_nxt = load_word;
          count_nxt = load_cnt;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (count == '0) begin
            state_nxt = IDLE;
          end else begin
            shreg_nxt = shreg << DIGIT_W;
            count_nxt = count - IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; digit/last are masked outside SHIFT.
  assign out_digit = out_valid ? shreg[DATA_W-1 -: DIGIT_W] : '0;
  assign out_last  = out_valid && (count == '0);
  assign out_idx   = count;

endmodule

// File: tb/tb_nibble_unpacker.sv
// Directed + randomised bench for nibble_unpacker against a digit-list reference model.
module tb_nibble_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_digit;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  out_idx;

  int errors = 0;
  int checks = 0;
  int q_dig[$];
  int q_idx[$];
  int seq_v[$];
  int seq_d[$];

  always #5 clk = ~clk;

  nibble_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_digit (out_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the word's hex digits by place value, optionally without leading zeros.
  function automatic void build_expect(input logic [15:0] w);
    int n;
    int v;
    v = int'(w);
    n = 4;
    q_dig.delete();
    q_idx.delete();
`ifdef NIBBLE_UNPACK_LZS_EN
    while (n > 1 && v < (16 ** (n - 1))) n--;
`endif
    for (int p = n - 1; p >= 0; p--) begin
      q_dig.push_back((v / (16 ** p)) % 16);
      q_idx.push_back(p);
    end
  endfunction

  // Load one word, drain it with optional stalls and junk on the input side.
  task automatic run_word(input logic [15:0] w, input bit rnd, input int stall_at);
    int stalls;
    build_expect(w);
    in_word   = w;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < q_dig.size(); k++) begin
      stalls = (k == stall_at) ? 3 : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s <= stalls; s++) begin
        check("out_valid", out_valid, 1);
        check("out_digit", out_digit, q_dig[k]);
        check("out_idx", out_idx, q_idx[k]);
        check("out_last", out_last, (k == q_dig.size() - 1) ? 1 : 0);
        check("in_ready_busy", in_ready, 0);
        out_ready = (s == stalls);
        in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        in_word   = 16'($urandom);
        step();
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("in_ready_done", in_ready, 1);
    check("out_valid_done", out_valid, 0);
  endtask

  initial begin
    logic [15:0] w;
    int n1;

    rst = 1'b0; in_word = '0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_digit", out_digit, 0);
    check("rst_out_idx", out_idx, 0);
    rst = 1'b1;
    step();

    run_word(16'h1248, 1'b0, -1);
    run_word(16'hA5C3, 1'b0, 1);

    // Input offered mid-stream must be ignored.
    build_expect(16'h1234);
    in_word = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_word = 16'hFFFF;
    for (int k = 0; k < q_dig.size(); k++) begin
      check("ign_digit", out_digit, q_dig[k]);
      check("ign_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    check("ign_in_ready_done", in_ready, 1);
    step();
    check("ign_no_reload", out_valid, 0);

    // Reset mid-word aborts the remaining digits.
    build_expect(16'hBEEF);
    in_word = 16'hBEEF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("abort_digit", out_digit, q_dig[k]);
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_digit_zero", out_digit, 0);
    check("abort_idx_zero", out_idx, 0);
    check("abort_last_zero", out_last, 0);
    step();
    check("abort_stays_idle", out_valid, 0);
    run_word(16'h0001, 1'b0, -1);

    // Back-to-back with in_valid held: exactly one idle cycle between words.
    seq_v.delete(); seq_d.delete();
    build_expect(16'h0F0F);
    n1 = q_dig.size();
    foreach (q_dig[i]) begin seq_v.push_back(1); seq_d.push_back(q_dig[i]); end
    seq_v.push_back(0); seq_d.push_back(0);
    build_expect(16'hF0F0);
    foreach (q_dig[i]) begin seq_v.push_back(1); seq_d.push_back(q_dig[i]); end
    in_word = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_word = 16'hF0F0;
    for (int c = 0; c < seq_v.size(); c++) begin
      check("b2b_valid", out_valid, seq_v[c]);
      if (seq_v[c] == 1) check("b2b_digit", out_digit, seq_d[c]);
      if (c == n1 + 1) in_valid = 1'b0;
      step();
    end
    out_ready = 1'b0;
    check("b2b_in_ready_done", in_ready, 1);

    run_word(16'h0048, 1'b0, -1);
    run_word(16'h0000, 1'b0, -1);
    run_word(16'h7000, 1'b0, -1);

    // Random words, with a random number of top digits forced to zero.
    for (int r = 0; r < 40; r++) begin
      w = 16'($urandom);
      w = w >> (4 * $urandom_range(0, 3));
      run_word(w, 1'b1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_unpacker.md
Name: nibble_unpacker

Overview:
Inverse of the team's nibble-entry packer, which shifts digits left by 4 and accumulates them into a 16-bit word. This block takes a packed word and emits its 4-bit digits serially, most-significant first. It uses a valid/ready handshake on both sides. It feeds per-digit consumers on the DE10-Lite board, such as the 7-segment scan driver and the UART hex printer.

Parameters:
DATA_W, 16, packed word width; must be a multiple of DIGIT_W.
DIGIT_W, 4, width of one emitted digit.
NUM_DIGITS, DATA_W/DIGIT_W (derived localparam, 4), digits per word.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-low (rst==0 resets on the clk edge).
in_word  input  DATA_W  packed word to unpack.
in_valid  input  1  in_word is valid.
in_ready  output  1  block can accept a word.
out_digit  output  DIGIT_W  current digit, MS digit first.
out_valid  output  1  out_digit is valid.
out_ready  input  1  consumer accepts out_digit.
out_last  output  1  out_digit is the final digit of the word.
out_idx  output  2 (clog2 NUM_DIGITS)  position of the current digit; NUM_DIGITS-1 = most significant, 0 = least significant.

Behaviour:
- States: IDLE and SHIFT.
- Reset (rst==0 at clk edge):
  - state=IDLE; shift register=0; count=0.
  - in_ready=1, out_valid=0, out_last=0, out_digit=0, out_idx=0.
  - Reset mid-word aborts it. Remaining digits are discarded and nothing further is emitted.
- IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid: load the shift register with in_word, set count=NUM_DIGITS-1, go to SHIFT.
- SHIFT:
  - in_ready=0. in_valid is ignored; no queuing or overwrite.
  - out_valid=1.
  - out_digit = shift register[DATA_W-1 -: DIGIT_W].
  - out_idx=count.
  - out_last=(count==0).
- Transfer: occurs on a clk edge with out_valid && out_ready.
  - If count==0: go to IDLE.
  - Otherwise: shift the register left by DIGIT_W, zero-filling; decrement count.
- No transfer (out_ready=0): digit, idx and last are held stable. Hold is unlimited.
- Latency:
  - First digit is valid the cycle after the load edge.
  - With out_ready held high, one digit per cycle: NUM_DIGITS cycles per word.
  - in_ready returns the cycle after the last transfer. Back-to-back throughput is 1 word per NUM_DIGITS+1 cycles.
- Width rules:
  - The shifter is pure; no arithmetic on data.
  - count wraps never; it saturates at 0 by construction.
- All outputs are registered or decoded from registered state only; no combinational in→out path.

Optional Feature:
Macro: NIBBLE_UNPACK_LZS_EN (leading-zero suppression).
- Defined:
  - On load, count z = number of leading zero digits in in_word, capped at NUM_DIGITS-1.
  - Preload the shift register with in_word << (z*DIGIT_W) and set count=NUM_DIGITS-1-z.
  - Only significant digits are emitted. A zero word emits exactly one digit 0, with out_idx=0 and out_last=1.
- Undefined: all NUM_DIGITS digits are always emitted, and the zero-count logic is not compiled.

Decomposition:
- Package nibble_pkg holds:
  - DIGIT_W default.
  - state enum {IDLE, SHIFT}.
  - function clog2 for the idx width.
  - The same package is shared with the packer.
- Sub-module lead_zero_cnt (combinational priority encoder: word → z) exists only under NIBBLE_UNPACK_LZS_EN. It is the one natural split.

Test Plan:
1. Load 0x1248 with out_ready=1 → digits 1,2,4,8 on consecutive cycles; out_idx 3,2,1,0; out_last only with 8; in_ready=1 the next cycle.
2. Load 0xA5C3, out_ready low for 3 cycles on the second digit → 0x5 held stable with idx=2; then 0xC, 0x3 emitted; no digit lost or duplicated.
3. Load 0x1234; at digit 0x2, assert in_valid with 0xFFFF → ignored; stream continues 3,4 and in_ready=0 throughout.
4. Load 0xBEEF, drive rst=0 after the second digit → next cycle out_valid=0, in_ready=1, all outputs 0; a following load of 0x0001 emits 0,0,0,1.
5. Back-to-back 0x0F0F then 0xF0F0 with in_valid held → 0,F,0,F, one idle cycle, then F,0,F,0.
6. With NIBBLE_UNPACK_LZS_EN: 0x0048 → 4 (idx 1), 8 (idx 0, last); 0x0000 → single 0 with last=1; 0x7000 → 7,0,0,0.
